// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - issues one vector op element-by-element to a shared element ALU
// Optional lane masking with `define VEC_ALU_SEQ_MASK_EN.
module vec_alu_sequencer #(
  parameter int ELEMENT_SIZE = 16,
  parameter int NUM_ELEMENTS = 4,
  parameter int IDX_W        = $clog2(NUM_ELEMENTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       opcode,
  input  logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] vec_a,
  input  logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] vec_b,
`ifdef VEC_ALU_SEQ_MASK_EN
  input  logic [NUM_ELEMENTS-1:0]          mask,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] vec_result,
  output logic [ELEMENT_SIZE-1:0]          elem_a,
  output logic [ELEMENT_SIZE-1:0]          elem_b,
  output logic [2:0]                       elem_op,
  input  logic [ELEMENT_SIZE-1:0]          elem_result
);

  localparam int VW = NUM_ELEMENTS * ELEMENT_SIZE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [VW-1:0]    a_lat, b_lat, buffer, buffer_next;
  logic [2:0]       op_lat;
  logic             last, lane_en;

`ifdef VEC_ALU_SEQ_MASK_EN
  logic [NUM_ELEMENTS-1:0] mask_lat;
  assign lane_en = mask_lat[idx];
`else
  assign lane_en = 1'b1;
`endif

  assign last = (idx == IDX_W'(NUM_ELEMENTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      op_lat     <= '0;
      buffer     <= '0;
      vec_result <= '0;
`ifdef VEC_ALU_SEQ_MASK_EN
      mask_lat   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_lat  <= vec_a;
            b_lat  <= vec_b;
            op_lat <= opcode;
            idx    <= '0;
`ifdef VEC_ALU_SEQ_MASK_EN
            mask_lat <= mask;
`endif
          end
        end
        RUN: begin
          buffer <= buffer_next;
          // The final lane is folded in here so vec_result is complete when done rises.
          if (last) vec_result <= buffer_next;
          else      idx        <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done        = 1'b0;
    elem_a      = '0;
    elem_b      = '0;
    elem_op     = '0;
    buffer_next = buffer;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        elem_op = op_lat;
        if (lane_en) begin
          elem_a = a_lat[idx*ELEMENT_SIZE +: ELEMENT_SIZE];
          elem_b = b_lat[idx*ELEMENT_SIZE +: ELEMENT_SIZE];
        end
        buffer_next[idx*ELEMENT_SIZE +: ELEMENT_SIZE] = lane_en ? elem_result : '0;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
Issue/collect controller for the element-level vector ALU (alu_element_vec). It accepts one whole vector operation (NUM_ELEMENTS lanes of A and B, plus a 3-bit opcode) through a start/done handshake. It streams one element pair per clock into a single shared element ALU and gathers each element result into a result vector. It sits between the vector register file / decode stage and the element ALU, acting as the initiator side of the element ALU interface.

Parameters:
ELEMENT_SIZE, 16, width of one vector element in bits (matches the element ALU).
NUM_ELEMENTS, 4, lanes per vector, >=2.
IDX_W, $clog2(NUM_ELEMENTS), element index counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a vector operation; sampled only in IDLE.
opcode  in  3  ALU opcode for the whole vector; 3'b000 = add.
vec_a  in  NUM_ELEMENTS*ELEMENT_SIZE  operand A; element i at [i*ELEMENT_SIZE +: ELEMENT_SIZE].
vec_b  in  NUM_ELEMENTS*ELEMENT_SIZE  operand B; same packing.
busy  out  1  high in RUN and DONE.
done  out  1  one-cycle pulse; vec_result valid from this cycle.
vec_result  out  NUM_ELEMENTS*ELEMENT_SIZE  result vector; same packing.
elem_a  out  ELEMENT_SIZE  to element ALU elementA.
elem_b  out  ELEMENT_SIZE  to element ALU elementB.
elem_op  out  3  to element ALU opcode.
elem_result  in  ELEMENT_SIZE  from element ALU result (combinational, same cycle).

Behaviour:
- Reset (async assert, any state): state=IDLE, idx=0, busy=0, done=0, vec_result=0, all operand/opcode latches=0, so elem_a/elem_b/elem_op=0.
- FSM states IDLE, RUN, DONE.
- IDLE: busy=0, done=0; elem_* driven 0.
  - On start=1 at the edge: latch vec_a, vec_b, opcode; idx<=0; go RUN.
  - vec_result holds its previous value.
- RUN: busy=1.
  - elem_a = latched A[idx], elem_b = latched B[idx], elem_op = latched opcode. All are registered-sourced (no combinational path from start/vec_* inputs).
  - Each edge: internal buffer[idx] <= elem_result.
  - If idx==NUM_ELEMENTS-1, go DONE; else idx<=idx+1.
- DONE: vec_result <= buffer, registered on the RUN->DONE edge, so it is valid while done=1. done=1 and busy=1 for exactly one cycle, then go IDLE.
- Latency: start sampled at edge E0; RUN occupies the NUM_ELEMENTS cycles after E0; done is high in cycle NUM_ELEMENTS+1 after E0. Total busy span is NUM_ELEMENTS+1 cycles.
- start while busy (RUN or DONE) is ignored, with no queueing. start held high continuously gives back-to-back operations every NUM_ELEMENTS+2 cycles.
- Changes to vec_a/vec_b/opcode after acceptance do not affect the running operation.
- Arithmetic is fully owned by the element ALU. The sequencer does no width extension and no carry handling: results are ELEMENT_SIZE bits as returned, and wrap-around is preserved.
- vec_result is stable between done pulses and changes only on the RUN->DONE edge.
- Reset mid-RUN: abort immediately. No done pulse. vec_result clears to 0.

Optional Feature:
VEC_ALU_SEQ_MASK_EN
- With the macro defined: add port mask in NUM_ELEMENTS, latched with the operands at start.
  - Lanes with mask[i]=0 still consume their RUN cycle, so latency is unchanged.
  - For those lanes elem_a/elem_b are driven 0 and buffer[i] <= 0 instead of elem_result.
- Without the macro: no mask port; all lanes are active.

Test Plan:
- Bench setup: NUM_ELEMENTS=4, ELEMENT_SIZE=16, connected to alu_element_vec.
- Add: A={8,1,100,16'hFFFF}, B={5,2,200,16'h0001}, op=000, start 1 cycle -> done exactly 5 cycles after the start edge; vec_result={13,3,300,16'h0000}; busy high for 5 cycles.
- Streaming check: same stimulus -> in RUN cycles 1..4, elem_a/elem_b = (8,5),(1,2),(100,200),(16'hFFFF,1) in order; elem_op=000 every RUN cycle; elem_a=elem_b=0 in IDLE.
- Ignored start: pulse start again in RUN cycle 2 with A={1,1,1,1} -> first result unchanged, exactly one done pulse, no second operation.
- Input change after acceptance: change vec_a to all 7 one cycle after start -> result still {13,3,300,0}.
- Reset mid-op: assert rst asynchronously in RUN cycle 3 -> busy=0 and vec_result=0 immediately, no done; a new start after release with A=B={1,2,3,4} -> {2,4,6,8}.
- Mask (with VEC_ALU_SEQ_MASK_EN): mask=4'b0101, add stimulus -> vec_result={13,0,300,0}; done still 5 cycles after start.
